mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
Iterative multiply/divide unit, directly downstream of the register file. Consumes the a/b read operands on a start pulse and computes MULT/MULTU/DIV/DIVU over 32 iterations. Holds the architectural HI/LO registers, which feed the write-back mux for MFHI/MFLO. Supports MTHI/MTLO writes from write-back data.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only when busy=0
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
a  input  WIDTH  rs operand (multiplicand/dividend)
b  input  WIDTH  rt operand (multiplier/divisor)
hi_we  input  1  MTHI write enable
lo_we  input  1  MTLO write enable
wdata  input  WIDTH  MTHI/MTLO data
busy  output  1  operation in progress
done  output  1  one-cycle pulse: hi/lo hold the new result
div_by_zero  output  1  valid with done; set for DIV/DIVU with b=0
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset, async, any state: state=IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0; the in-flight operation is discarded.
- States:
  - IDLE.
  - RUN: counter 0..WIDTH-1.
  - DONE: lasts exactly one cycle.
- IDLE or DONE, start=1 at edge E0: latch op, |a|, |b|, sign flags; counter=0; state -> RUN; busy=1 from E0.
- RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per edge.
- Edge E32 (WIDTH-th iteration): final step plus sign correction written to hi/lo; state -> DONE; busy=0; done=1 for the cycle after E32.
- Latency: result visible 32 edges after the accepting edge.
- DONE -> IDLE on the next edge unless start=1; start=1 in DONE is accepted (back-to-back, no bubble).
- Working registers are separate from hi/lo; hi/lo keep their old values throughout RUN.
- Multiply results:
  - hi:lo = 64-bit product.
  - Signed: negate the 64-bit product when sign(a) xor sign(b).
- Divide results:
  - lo = quotient, hi = remainder.
  - Quotient sign = sign(a) xor sign(b); remainder sign = sign(a).
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wraps, no flag).
- Divide by zero:
  - Normal 32-cycle latency.
  - Result hi=a (as given), lo=0xFFFFFFFF for both DIV and DIVU.
  - div_by_zero=1 during the done cycle; cleared on the next accepted start.
- start while busy=1: ignored, no side effects.
- hi_we/lo_we:
  - Honoured only when busy=0 and start=0; hi/lo updated at that edge.
  - Ignored while busy=1.
  - Dropped if coincident with an accepted start (start wins).
  - Write in the DONE cycle overwrites the just-produced result.
- MULT/MULTU never set div_by_zero.

Decomposition:
- Shared package:
  - op encodings MDU_MULT/MULTU/DIV/DIVU.
  - state encoding IDLE/RUN/DONE.
  - constant MDU_ITER=32.
- One natural sub-module, mdu_step: combinational single-iteration datapath.
  - Inputs: op, partial remainder/product, operand.
  - Outputs: next partial state.
- Top owns the FSM, counter, sign fix-up, and HI/LO.

Test Plan:
1. MULT a=0xFFFFFFFD (-3), b=7 -> 32 edges later done=1 for 1 cycle, hi=0xFFFFFFFF, lo=0xFFFFFFEB, busy high exactly 32 cycles.
2. MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; then DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
3. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0; DIVU a=5, b=0 -> hi=5, lo=0xFFFFFFFF, div_by_zero=1.
4. DIVU 100/7 started; at cycle 10 assert start (MULT 2*2) and hi_we (wdata=0xDEAD) -> both ignored; result lo=14, hi=2; MTLO 0x1234 after done -> lo=0x1234.
5. Back-to-back: start held in DONE cycle of MULTU 3*4 with DIVU 9/3 -> first done hi=0, lo=12; second done exactly 32 edges later, lo=3, hi=0.
6. rst_n low at cycle 15 of a DIV -> busy, done, hi, lo go 0 immediately (async), no done pulse; after release, MULT 6*7 completes with lo=42.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// controller states and the iteration count.
package mult_div_unit_pkg;

    localparam int MDU_ITER = 32;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    function automatic logic op_is_div(input mdu_op_e op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic op_is_signed(input mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mult_div_unit_mdu_step.sv
// One iteration of the unsigned magnitude datapath.
// Multiply: part_hi:part_lo is the running product with the multiplier in
// the low half; operand is the multiplicand (shift-add, LSB first).
// Divide: part_hi is the partial remainder, part_lo holds the dividend bits
// still to be consumed and collects quotient bits; operand is the divisor
// (restoring shift-subtract, MSB first).
module mdu_step
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = MDU_ITER
) (
    input  mdu_op_e          op,
    input  logic [WIDTH-1:0] part_hi,
    input  logic [WIDTH-1:0] part_lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] next_hi,
    output logic [WIDTH-1:0] next_lo
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;

    // Compute both candidate updates and select by operation class.
    always_comb begin
        sum     = {1'b0, part_hi} + (part_lo[0] ? {1'b0, operand} : '0);
        shifted = {part_hi, part_lo[WIDTH-1]};
        next_hi = sum[WIDTH:1];
        next_lo = {sum[0], part_lo[WIDTH-1:1]};
        if (op_is_div(op)) begin
            if (shifted >= {1'b0, operand}) begin
                // Difference is below the divisor, so it fits in WIDTH bits.
                next_hi = shifted[WIDTH-1:0] - operand;
                next_lo = {part_lo[WIDTH-2:0], 1'b1};
            end else begin
                next_hi = shifted[WIDTH-1:0];
                next_lo = {part_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO pair.
// Handshake: start is a request that is accepted on any rising edge where
// busy=0 (IDLE or DONE); a request while busy=1 is dropped without effect.
// done pulses for one cycle when hi/lo carry the new result. Operands are
// converted to magnitudes on acceptance and the sign is fixed on the last step.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = MDU_ITER
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       state_dbg
);

    localparam int CW = $clog2(WIDTH);

    mdu_state_e         state_q, state_d;
    logic [CW-1:0]      count_q;
    mdu_op_e            op_q;
    logic [WIDTH-1:0]   work_hi_q, work_lo_q, operand_q;
    logic               sign_a_q, neg_q_q, bzero_q, dbz_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    mdu_op_e            op_in;
    logic               accept, last_step, in_signed, a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   res_hi, res_lo;

    assign op_in     = mdu_op_e'(op);
    assign accept    = start && (state_q != ST_RUN);
    assign last_step = (state_q == ST_RUN) && (count_q == CW'(WIDTH - 1));
    assign in_signed = op_is_signed(op_in);
    assign a_neg     = in_signed && a[WIDTH-1];
    assign b_neg     = in_signed && b[WIDTH-1];
    assign mag_a     = a_neg ? -a : a;
    assign mag_b     = b_neg ? -b : b;

    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;
    assign state_dbg   = state_q;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .op      (op_q),
        .part_hi (work_hi_q),
        .part_lo (work_lo_q),
        .operand (operand_q),
        .next_hi (step_hi),
        .next_lo (step_lo)
    );

    // Sign fix-up of the final step; a zero divisor forces the quotient to
    // all ones, while the remainder path already reproduces the dividend.
    always_comb begin
        prod     = {step_hi, step_lo};
        prod_fix = neg_q_q ? -prod : prod;
        res_hi   = prod_fix[2*WIDTH-1:WIDTH];
        res_lo   = prod_fix[WIDTH-1:0];
        if (op_is_div(op_q)) begin
            res_hi = sign_a_q ? -step_hi : step_hi;
            res_lo = bzero_q ? '1 : (neg_q_q ? -step_lo : step_lo);
        end
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state and status outputs.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN: begin
                busy = 1'b1;
                if (last_step) state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = start ? ST_RUN : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand capture, iteration, result commit and MTHI/MTLO writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            op_q      <= MDU_MULT;
            work_hi_q <= '0;
            work_lo_q <= '0;
            operand_q <= '0;
            sign_a_q  <= 1'b0;
            neg_q_q   <= 1'b0;
            bzero_q   <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else if (accept) begin
            count_q   <= '0;
            op_q      <= op_in;
            work_hi_q <= '0;
            work_lo_q <= op_is_div(op_in) ? mag_a : mag_b;
            operand_q <= op_is_div(op_in) ? mag_b : mag_a;
            sign_a_q  <= a_neg;
            neg_q_q   <= a_neg ^ b_neg;
            bzero_q   <= (b == '0);
            dbz_q     <= 1'b0;
        end else if (state_q == ST_RUN) begin
            count_q   <= count_q + CW'(1);
            work_hi_q <= step_hi;
            work_lo_q <= step_lo;
            if (last_step) begin
                hi_q  <= res_hi;
                lo_q  <= res_lo;
                dbz_q <= op_is_div(op_q) && bzero_q;
            end
        end else begin
            if (hi_we) hi_q <= wdata;
            if (lo_we) lo_q <= wdata;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: an arithmetic reference model tracks busy/done
// and HI/LO per cycle, plus literal expectations for the directed vectors.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0, wdata = '0;
    logic        hi_we = 1'b0, lo_we = 1'b0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;
    logic [1:0]  state_dbg;

    int tests = 0;
    int fails = 0;

    mult_div_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy),
        .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo),
        .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Returns {div_by_zero, hi, lo} from plain integer arithmetic.
    function automatic logic [64:0] model_result(input logic [1:0] m_op,
                                                 input logic [31:0] ma,
                                                 input logic [31:0] mb);
        logic [63:0] p;
        longint      sa, sb;
        logic [31:0] q, r;
        case (m_op)
            2'b00: begin
                p = longint'($signed(ma)) * longint'($signed(mb));
                return {1'b0, p};
            end
            2'b01: begin
                p = {32'h0, ma} * {32'h0, mb};
                return {1'b0, p};
            end
            default: begin
                if (mb == 32'h0) return {1'b1, ma, 32'hFFFF_FFFF};
                if (m_op == 2'b10) begin
                    sa = longint'($signed(ma));
                    sb = longint'($signed(mb));
                    q  = 32'(sa / sb);
                    r  = 32'(sa % sb);
                end else begin
                    q = ma / mb;
                    r = ma % mb;
                end
                return {1'b0, r, q};
            end
        endcase
    endfunction

    int          m_left = 0;
    bit          m_done = 1'b0;
    bit          m_dbz = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [64:0] m_pend = '0;

    // Model: an accepted request finishes 32 edges later; writes only when idle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0; m_done = 1'b0; m_dbz = 1'b0; m_hi = '0; m_lo = '0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_dbz  = m_pend[64];
                    m_hi   = m_pend[63:32];
                    m_lo   = m_pend[31:0];
                    m_done = 1'b1;
                end
            end else if (start) begin
                m_pend = model_result(op, a, b);
                m_left = 32;
                m_dbz  = 1'b0;
            end else begin
                if (hi_we) m_hi = wdata;
                if (lo_we) m_lo = wdata;
            end
        end
    end

    // Compare process: outputs against the model every falling edge.
    always @(negedge clk) begin
        check("busy", {31'h0, busy}, {31'h0, m_left > 0});
        check("done", {31'h0, done}, {31'h0, m_done});
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
        if (m_done) check("dbz", {31'h0, div_by_zero}, {31'h0, m_dbz});
    end

    // ---------------- driver tasks ----------------
    task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns at the falling edge where done is high; bounded.
    task automatic wait_done(input string name, output int busy_cycles);
        busy_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            if (done === 1'b1) return;
            if (busy === 1'b1) busy_cycles++;
            @(negedge clk);
        end
        tests++;
        fails++;
        $display("FAIL %s: no done within 100 cycles", name);
    endtask

    // ---------------- directed tests ----------------
    logic [1:0]  t_op  [4] = '{2'b00, 2'b10, 2'b10, 2'b11};
    logic [31:0] t_a   [4] = '{32'h7FFF_FFFF, 32'h0000_0007, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    logic [31:0] t_b   [4] = '{32'h8000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h0000_0001};
    logic [31:0] t_ehi [4] = '{32'hC000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
    logic [31:0] t_elo [4] = '{32'h8000_0000, 32'hFFFF_FFFD, 32'h0000_0003, 32'hFFFF_FFFF};

    initial begin
        int bc;
        int pulses;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_state", {30'h0, state_dbg}, 32'h0);
        rst_n = 1'b1;

        // 1: MULT -3 * 7
        start_op(2'b00, 32'hFFFF_FFFD, 32'h7);
        wait_done("t1_done", bc);
        check("t1_busy_len", bc, 32);
        check("t1_hi", hi, 32'hFFFF_FFFF);
        check("t1_lo", lo, 32'hFFFF_FFEB);
        @(negedge clk);
        check("t1_done_once", {31'h0, done}, 32'h0);

        // 2: MULTU max*max, then DIV -7/2
        start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("t2a_done", bc);
        check("t2a_hi", hi, 32'hFFFF_FFFE);
        check("t2a_lo", lo, 32'h0000_0001);
        start_op(2'b10, 32'hFFFF_FFF9, 32'h2);
        wait_done("t2b_done", bc);
        check("t2b_hi", hi, 32'hFFFF_FFFF);
        check("t2b_lo", lo, 32'hFFFF_FFFD);

        // 3: DIV overflow case, DIVU by zero
        start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("t3a_done", bc);
        check("t3a_hi", hi, 32'h0);
        check("t3a_lo", lo, 32'h8000_0000);
        check("t3a_dbz", {31'h0, div_by_zero}, 32'h0);
        start_op(2'b11, 32'h5, 32'h0);
        wait_done("t3b_done", bc);
        check("t3b_busy_len", bc, 32);
        check("t3b_hi", hi, 32'h5);
        check("t3b_lo", lo, 32'hFFFF_FFFF);
        check("t3b_dbz", {31'h0, div_by_zero}, 32'h1);

        // 4: start and MTHI during RUN are ignored; MTLO afterwards lands
        start_op(2'b11, 32'd100, 32'd7);
        repeat (8) @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'h2; b = 32'h2; hi_we = 1'b1; wdata = 32'hDEAD;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        wait_done("t4_done", bc);
        check("t4_hi", hi, 32'd2);
        check("t4_lo", lo, 32'd14);
        @(negedge clk);
        lo_we = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        lo_we = 1'b0;
        check("t4_mtlo", lo, 32'h1234);
        check("t4_hi_kept", hi, 32'd2);

        // 5: back-to-back start in the DONE cycle
        start_op(2'b01, 32'd3, 32'd4);
        wait_done("t5a_done", bc);
        check("t5a_hi", hi, 32'h0);
        check("t5a_lo", lo, 32'd12);
        start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done("t5b_done", bc);
        check("t5b_busy_len", bc, 32);
        check("t5b_hi", hi, 32'h0);
        check("t5b_lo", lo, 32'd3);

        // extra signed/unsigned vectors
        for (int i = 0; i < 4; i++) begin
            start_op(t_op[i], t_a[i], t_b[i]);
            wait_done("vec_done", bc);
            check("vec_hi", hi, t_ehi[i]);
            check("vec_lo", lo, t_elo[i]);
        end

        // 6: async reset mid-DIV
        start_op(2'b10, 32'hFFFF_FF9C, 32'd7);
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_busy", {31'h0, busy}, 32'h0);
        check("t6_done", {31'h0, done}, 32'h0);
        check("t6_hi", hi, 32'h0);
        check("t6_lo", lo, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        check("t6_no_done", pulses, 0);
        start_op(2'b00, 32'd6, 32'd7);
        wait_done("t6_done2", bc);
        check("t6_hi2", hi, 32'h0);
        check("t6_lo2", lo, 32'd42);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
